// File: rtl/ext_pipe.sv
// Operand extender: picks an immediate or load lane, sign/zero extends it and buffers it in a small FIFO.
// Define EXT_BIGEND_EN to map load byte/halfword lanes big-endian.
module ext_pipe #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [2:0]        SEL,
  input  logic              SZE_CTRL,
  input  logic [31:0]       IR2,
  input  logic [DATA_W-1:0] LOAD_DATA,
  input  logic [1:0]        ADDR_LO,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [CNT_W-1:0]  COUNT,
  output logic              ERR
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_nxt;
  logic              in_ready_q, err_q;
  logic              push, pop, bad_req;
  logic [31:0]       ld_word;
  logic [1:0]        byte_lane;
  logic              half_lane;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic              fill;
  logic [63:0]       ext64;
  logic [DATA_W-1:0] ext_val;
  logic              unused_ir_hi;

  assign unused_ir_hi = ^IR2[31:24];

  // Only the low 32 bits of the load word carry lanes; narrower words are zero padded.
  generate
    if (DATA_W >= 32) begin : g_ld_wide
      assign ld_word = LOAD_DATA[31:0];
      if (DATA_W > 32) begin : g_ld_hi
        logic unused_ld_hi;
        assign unused_ld_hi = ^LOAD_DATA[DATA_W-1:32];
      end
    end else begin : g_ld_narrow
      assign ld_word = {{(32-DATA_W){1'b0}}, LOAD_DATA};
    end
  endgenerate

`ifdef EXT_BIGEND_EN
  assign byte_lane = ~ADDR_LO;
  assign half_lane = ~ADDR_LO[1];
`else
  assign byte_lane = ADDR_LO;
  assign half_lane = ADDR_LO[1];
`endif

  assign lane_b = ld_word[{byte_lane, 3'b000} +: 8];
  assign lane_h = ld_word[{half_lane, 4'b0000} +: 16];

  // Extension is built at 64 bits so every DATA_W in range is a plain truncation.
  always_comb begin
    fill  = 1'b0;
    ext64 = '0;
    case (SEL)
      3'd0: begin fill = SZE_CTRL & IR2[11]; ext64 = {{52{fill}}, IR2[11:0]}; end
      3'd1: begin fill = SZE_CTRL & IR2[11]; ext64 = {{56{fill}}, IR2[11:8], IR2[3:0]}; end
      3'd2: begin fill = SZE_CTRL & IR2[7];  ext64 = {{56{fill}}, IR2[7:0]}; end
      3'd3: begin fill = SZE_CTRL & IR2[23]; ext64 = {{40{fill}}, IR2[23:0]}; end
      3'd4: begin fill = SZE_CTRL & lane_b[7];  ext64 = {{56{fill}}, lane_b}; end
      3'd5: begin fill = SZE_CTRL & lane_h[15]; ext64 = {{48{fill}}, lane_h}; end
      default: begin fill = 1'b0; ext64 = '0; end
    endcase
  end

  assign ext_val = ext64[DATA_W-1:0];
  assign bad_req = (SEL[2] & SEL[1]) | ((SEL == 3'd5) & ADDR_LO[0]);

  assign push      = IN_VALID & in_ready_q;
  assign pop       = OUT_VALID & OUT_READY;
  assign count_nxt = count_q + CNT_W'(push) - CNT_W'(pop);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
    end else if (FLUSH) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= ext_val;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q    <= count_nxt;
      err_q      <= err_q | (push & bad_req);
      // Ready comes from next occupancy so OUT_READY never reaches IN_READY combinationally.
      in_ready_q <= (count_nxt < CNT_W'(DEPTH));
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = (count_q != '0);
  assign OUT_DATA  = mem[rd_ptr];
  assign COUNT     = count_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_ext_pipe.sv
// Directed bench for ext_pipe: scoreboarded FIFO output plus explicit handshake/error/reset checks.
module tb_ext_pipe;

  logic        CLK = 1'b0;
  logic        nRESET, FLUSH, IN_VALID, IN_READY, SZE_CTRL;
  logic [2:0]  SEL;
  logic [31:0] IR2, LOAD_DATA, OUT_DATA;
  logic [1:0]  ADDR_LO;
  logic        OUT_VALID, OUT_READY, ERR;
  logic [1:0]  COUNT;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb [$];

  ext_pipe #(.DATA_W(32), .DEPTH(2)) dut (
    .CLK(CLK), .nRESET(nRESET), .FLUSH(FLUSH),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .SEL(SEL), .SZE_CTRL(SZE_CTRL), .IR2(IR2),
    .LOAD_DATA(LOAD_DATA), .ADDR_LO(ADDR_LO),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .COUNT(COUNT), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: pull the raw field and its width, then smear the top bit upward.
  function automatic logic [31:0] model(input logic [2:0] s, input logic z,
                                        input logic [31:0] ir, input logic [31:0] ld,
                                        input logic [1:0] a);
    logic [31:0] raw;
    int w;
    int lane;
    raw = 32'h0; w = 32;
    case (s)
      3'd0: begin raw = ir & 32'hFFF; w = 12; end
      3'd1: begin raw = (((ir >> 8) & 32'hF) << 4) | (ir & 32'hF); w = 8; end
      3'd2: begin raw = ir & 32'hFF; w = 8; end
      3'd3: begin raw = ir & 32'hFFFFFF; w = 24; end
      3'd4: begin
`ifdef EXT_BIGEND_EN
        lane = 3 - int'(a);
`else
        lane = int'(a);
`endif
        raw = (ld >> (8 * lane)) & 32'hFF; w = 8;
      end
      3'd5: begin
`ifdef EXT_BIGEND_EN
        lane = 1 - int'(a[1]);
`else
        lane = int'(a[1]);
`endif
        raw = (ld >> (16 * lane)) & 32'hFFFF; w = 16;
      end
      default: begin raw = 32'h0; w = 32; end
    endcase
    if (z && raw[w-1])
      for (int i = w; i < 32; i++) raw[i] = 1'b1;
    return raw;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus, called on a falling edge; returns on the next falling edge.
  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic z,
                               input logic [31:0] ir, input logic [31:0] ld,
                               input logic [1:0] a, input logic ordy, input logic fl);
    IN_VALID = v; SEL = s; SZE_CTRL = z; IR2 = ir; LOAD_DATA = ld;
    ADDR_LO = a; OUT_READY = ordy; FLUSH = fl;
    #1;
    if (fl) sb.delete();
    else begin
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) checkOutput("unexpected_pop", 64'(OUT_VALID), 64'd0);
        else checkOutput("head", 64'(OUT_DATA), 64'(sb.pop_front()));
      end
      if (IN_VALID && IN_READY) sb.push_back(model(s, z, ir, ld, a));
    end
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0; OUT_READY = 1'b0; FLUSH = 1'b0;
  endtask

  initial begin
    nRESET = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; SZE_CTRL = 1'b0; SEL = 3'd0;
    IR2 = 32'h0; LOAD_DATA = 32'h0; ADDR_LO = 2'd0; OUT_READY = 1'b0;
    #3;
    checkOutput("rst_out_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("rst_count", 64'(COUNT), 64'd0);
    checkOutput("rst_err", 64'(ERR), 64'd0);
    checkOutput("rst_out_data", 64'(OUT_DATA), 64'd0);
    checkOutput("rst_in_ready", 64'(IN_READY), 64'd0);
    @(negedge CLK); @(negedge CLK);
    nRESET = 1'b1;
    #1 checkOutput("in_ready_at_release", 64'(IN_READY), 64'd0);
    @(negedge CLK);
    checkOutput("in_ready_after_release", 64'(IN_READY), 64'd1);

    $display("[TB] sign/zero extension");
    applyStimulus(1, 3'd0, 1, 32'h00000801, 32'h0, 2'd0, 0, 0);
    checkOutput("sext_valid", 64'(OUT_VALID), 64'd1);
    checkOutput("sext_count", 64'(COUNT), 64'd1);
    checkOutput("sext_data", 64'(OUT_DATA), 64'hFFFFF801);
    applyStimulus(0, 3'd0, 0, 32'h0, 32'h0, 2'd0, 1, 0);
    applyStimulus(1, 3'd0, 0, 32'h00000801, 32'h0, 2'd0, 0, 0);
    checkOutput("zext_data", 64'(OUT_DATA), 64'h00000801);
    applyStimulus(0, 3'd0, 0, 32'h0, 32'h0, 2'd0, 1, 0);
    checkOutput("empty_after_pop", 64'(OUT_VALID), 64'd0);

    $display("[TB] lane extraction and back-pressure");
    applyStimulus(1, 3'd4, 1, 32'h0, 32'h8899AABB, 2'd2, 0, 0);
`ifdef EXT_BIGEND_EN
    checkOutput("byte_lane", 64'(OUT_DATA), 64'hFFFFFFAA);
`else
    checkOutput("byte_lane", 64'(OUT_DATA), 64'hFFFFFF99);
`endif
    applyStimulus(1, 3'd5, 0, 32'h0, 32'h8899AABB, 2'd2, 0, 0);
    checkOutput("full_count", 64'(COUNT), 64'd2);
    checkOutput("full_in_ready", 64'(IN_READY), 64'd0);
    applyStimulus(1, 3'd2, 0, 32'h000000C3, 32'h0, 2'd0, 0, 0);
    checkOutput("held_count", 64'(COUNT), 64'd2);
    applyStimulus(1, 3'd2, 0, 32'h000000C3, 32'h0, 2'd0, 1, 0);
    checkOutput("ready_after_pop", 64'(IN_READY), 64'd1);
    checkOutput("count_after_pop", 64'(COUNT), 64'd1);
`ifdef EXT_BIGEND_EN
    checkOutput("half_lane", 64'(OUT_DATA), 64'h0000AABB);
`else
    checkOutput("half_lane", 64'(OUT_DATA), 64'h00008899);
`endif
    applyStimulus(1, 3'd2, 0, 32'h000000C3, 32'h0, 2'd0, 1, 0);
    checkOutput("push_pop_count", 64'(COUNT), 64'd1);
    for (int k = 0; k < 8 && OUT_VALID; k++)
      applyStimulus(0, 3'd0, 0, 32'h0, 32'h0, 2'd0, 1, 0);
    checkOutput("drained", 64'(COUNT), 64'd0);

    $display("[TB] concurrent push/pop");
    applyStimulus(1, 3'd2, 1, 32'h0000007F, 32'h0, 2'd0, 0, 0);
    applyStimulus(1, 3'd3, 1, 32'h00800000, 32'h0, 2'd0, 1, 0);
    checkOutput("concurrent_count", 64'(COUNT), 64'd1);
    checkOutput("concurrent_head", 64'(OUT_DATA), 64'hFF800000);
    applyStimulus(1, 3'd1, 1, 32'h00000A05, 32'h0, 2'd0, 1, 0);
    checkOutput("split_imm", 64'(OUT_DATA), 64'hFFFFFFA5);
    checkOutput("legal_no_err", 64'(ERR), 64'd0);
    applyStimulus(0, 3'd0, 0, 32'h0, 32'h0, 2'd0, 1, 0);

    $display("[TB] error reporting and flush");
    applyStimulus(1, 3'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 0, 0);
    checkOutput("illegal_err", 64'(ERR), 64'd1);
    checkOutput("illegal_data", 64'(OUT_DATA), 64'd0);
    applyStimulus(1, 3'd5, 1, 32'h0, 32'h8899AABB, 2'd1, 0, 0);
    checkOutput("misalign_err", 64'(ERR), 64'd1);
    checkOutput("misalign_count", 64'(COUNT), 64'd2);
    applyStimulus(0, 3'd0, 0, 32'h0, 32'h0, 2'd0, 1, 0);
`ifdef EXT_BIGEND_EN
    checkOutput("misalign_data", 64'(OUT_DATA), 64'hFFFF8899);
`else
    checkOutput("misalign_data", 64'(OUT_DATA), 64'hFFFFAABB);
`endif
    applyStimulus(1, 3'd0, 0, 32'h00000123, 32'h0, 2'd0, 1, 1);
    checkOutput("flush_count", 64'(COUNT), 64'd0);
    checkOutput("flush_err", 64'(ERR), 64'd0);
    checkOutput("flush_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("flush_ready", 64'(IN_READY), 64'd1);

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1, 3'd2, 0, 32'h00000011, 32'h0, 2'd0, 0, 0);
    applyStimulus(1, 3'd2, 0, 32'h00000022, 32'h0, 2'd0, 0, 0);
    checkOutput("pre_reset_count", 64'(COUNT), 64'd2);
    #2 nRESET = 1'b0;
    #1;
    checkOutput("async_valid", 64'(OUT_VALID), 64'd0);
    checkOutput("async_count", 64'(COUNT), 64'd0);
    checkOutput("async_in_ready", 64'(IN_READY), 64'd0);
    sb.delete();
    @(negedge CLK);
    nRESET = 1'b1;
    @(negedge CLK);
    checkOutput("ready_after_reset", 64'(IN_READY), 64'd1);
    applyStimulus(1, 3'd0, 1, 32'h000007FF, 32'h0, 2'd0, 0, 0);
    checkOutput("post_reset_data", 64'(OUT_DATA), 64'h000007FF);
    applyStimulus(0, 3'd0, 0, 32'h0, 32'h0, 2'd0, 1, 0);
    checkOutput("final_count", 64'(COUNT), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
